// File: rtl/operand_bypass_unit.sv
// EX-stage forwarding network: picks the youngest matching in-flight result per source operand,
// zero-latency combinational lookup; a load-use match holds EX (one bubble) and is counted.
module operand_bypass_unit #(
    parameter int XLEN    = 64,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int RADDR_W = 5,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       stall_in,
    input  logic                       ex_valid,
    input  logic                       ex_reg_write,
    input  logic                       ex_is_load,
    input  logic [RADDR_W-1:0]         ex_rd,
    input  logic [XLEN-1:0]            ex_result,
    input  logic [XLEN-1:0]            mem_rdata,
    input  logic [NUM_SRC*RADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*XLEN-1:0]    src_data,
    output logic [NUM_SRC*XLEN-1:0]    fwd_data,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       load_use_hazard,
    output logic [31:0]                hazard_count
);

    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0][RADDR_W-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][XLEN-1:0]    data_q, data_d;
    // Only entry[0] can hold a pending load: the shift into entry[1] fills in mem_rdata.
    logic                          pend_q, pend_d;
    logic [31:0]                   hazard_count_q, hazard_count_d;
    logic [NUM_SRC-1:0]            src_haz;

    always_comb begin
        fwd_data = '0;
        fwd_sel  = '0;
        src_haz  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [RADDR_W-1:0] addr;
            logic [XLEN-1:0]    data;
            logic [SEL_W-1:0]   sel;
            logic               pend_win;
            addr     = src_addr[i*RADDR_W +: RADDR_W];
            data     = src_data[i*XLEN +: XLEN];
            sel      = '0;
            pend_win = 1'b0;
            // Walk oldest to youngest so the lowest matching index is the one kept.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (valid_q[k] && (rd_q[k] == addr) && (addr != '0)) begin
                    sel      = SEL_W'(k + 1);
                    data     = data_q[k];
                    pend_win = (k == 0) ? pend_q : 1'b0;
                end
            end
            fwd_data[i*XLEN +: XLEN]   = data;
            fwd_sel[i*SEL_W +: SEL_W]  = sel;
            src_haz[i]                 = pend_win;
        end
    end

    assign load_use_hazard = ex_valid && (|src_haz);

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        pend_d  = pend_q;
        if (flush) begin
            valid_d = '0;
        end else if (!stall_in) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                valid_d[k] = valid_q[k-1];
                rd_d[k]    = rd_q[k-1];
                data_d[k]  = data_q[k-1];
            end
            if (pend_q) begin
                data_d[1] = mem_rdata;
            end
            valid_d[0] = ex_valid && ex_reg_write && (ex_rd != '0) && !load_use_hazard;
            rd_d[0]    = ex_rd;
            data_d[0]  = ex_result;
            pend_d     = ex_is_load;
        end
    end

    always_comb begin
        hazard_count_d = hazard_count_q;
        if (load_use_hazard && (hazard_count_q != 32'hFFFF_FFFF)) begin
            hazard_count_d = hazard_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q        <= '0;
            rd_q           <= '0;
            data_q         <= '0;
            pend_q         <= 1'b0;
            hazard_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            rd_q           <= rd_d;
            data_q         <= data_d;
            pend_q         <= pend_d;
            hazard_count_q <= hazard_count_d;
        end
    end

    assign hazard_count = hazard_count_q;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed bench for operand_bypass_unit; expected outputs queued per step, popped and checked mid-cycle.
module tb_operand_bypass_unit;

    localparam int XLEN    = 64;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 2;
    localparam int RADDR_W = 5;
    localparam int SEL_W   = $clog2(DEPTH + 1);

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       flush;
    logic                       stall_in;
    logic                       ex_valid;
    logic                       ex_reg_write;
    logic                       ex_is_load;
    logic [RADDR_W-1:0]         ex_rd;
    logic [XLEN-1:0]            ex_result;
    logic [XLEN-1:0]            mem_rdata;
    logic [NUM_SRC*RADDR_W-1:0] src_addr;
    logic [NUM_SRC*XLEN-1:0]    src_data;
    logic [NUM_SRC*XLEN-1:0]    fwd_data;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic                       load_use_hazard;
    logic [31:0]                hazard_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [1:0] s0;
        logic [63:0] d0;
        bit         cd0;
        logic [1:0] s1;
        logic [63:0] d1;
        logic       haz;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    operand_bypass_unit #(
        .XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .RADDR_W(RADDR_W), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall_in(stall_in),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result), .mem_rdata(mem_rdata),
        .src_addr(src_addr), .src_data(src_data),
        .fwd_data(fwd_data), .fwd_sel(fwd_sel),
        .load_use_hazard(load_use_hazard), .hazard_count(hazard_count)
    );

    always #5 clk = ~clk;

    task automatic ex(input logic v, input logic rw, input logic ld,
                      input logic [4:0] rd, input logic [63:0] res);
        ex_valid     = v;
        ex_reg_write = rw;
        ex_is_load   = ld;
        ex_rd        = rd;
        ex_result    = res;
    endtask

    task automatic src(input logic [4:0] a0, input logic [63:0] d0,
                       input logic [4:0] a1, input logic [63:0] d1);
        src_addr = {a1, a0};
        src_data = {d1, d0};
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        assert (fwd_sel[0 +: SEL_W] === e.s0) else begin
            n_err++; $error("FAIL %s sel0 observed=%0d expected=%0d", e.tag, fwd_sel[0 +: SEL_W], e.s0);
        end
        if (e.cd0) begin
            n_cmp++;
            assert (fwd_data[0 +: XLEN] === e.d0) else begin
                n_err++; $error("FAIL %s data0 observed=%h expected=%h", e.tag, fwd_data[0 +: XLEN], e.d0);
            end
        end
        n_cmp++;
        assert (fwd_sel[SEL_W +: SEL_W] === e.s1) else begin
            n_err++; $error("FAIL %s sel1 observed=%0d expected=%0d", e.tag, fwd_sel[SEL_W +: SEL_W], e.s1);
        end
        n_cmp++;
        assert (fwd_data[XLEN +: XLEN] === e.d1) else begin
            n_err++; $error("FAIL %s data1 observed=%h expected=%h", e.tag, fwd_data[XLEN +: XLEN], e.d1);
        end
        n_cmp++;
        assert (load_use_hazard === e.haz) else begin
            n_err++; $error("FAIL %s hazard observed=%b expected=%b", e.tag, load_use_hazard, e.haz);
        end
        n_cmp++;
        assert (hazard_count === e.cnt) else begin
            n_err++; $error("FAIL %s count observed=%h expected=%h", e.tag, hazard_count, e.cnt);
        end
    endtask

    // Queue the expectation for the inputs just driven, check mid-cycle, then advance one edge.
    task automatic sc(input string tag, input logic [1:0] s0, input logic [63:0] d0, input bit cd0,
                      input logic [1:0] s1, input logic [63:0] d1, input logic haz, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.s0 = s0; e.d0 = d0; e.cd0 = cd0;
        e.s1 = s1; e.d1 = d1; e.haz = haz; e.cnt = cnt;
        sb.push_back(e);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall_in = 1'b0; mem_rdata = 64'hBEEF;
        ex(0, 0, 0, 0, 0);
        src(5, 64'h11, 0, 64'h22);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        sc("reset", 0, 64'h11, 1, 0, 64'h22, 0, 0);
        ex(1, 1, 0, 5, 64'hAA);
        sc("push5", 0, 64'h11, 1, 0, 64'h22, 0, 0);
        ex(0, 0, 0, 0, 0);
        sc("b2b", 1, 64'hAA, 1, 0, 64'h22, 0, 0);
        sc("age", 2, 64'hAA, 1, 0, 64'h22, 0, 0);

        ex(1, 1, 0, 3, 64'h1);
        src(0, 64'h44, 3, 64'h33);
        sc("y_push1", 0, 64'h44, 1, 0, 64'h33, 0, 0);
        ex(1, 1, 0, 3, 64'h2);
        sc("y_push2", 0, 64'h44, 1, 1, 64'h1, 0, 0);
        ex(1, 1, 0, 0, 64'h55);
        sc("youngest", 0, 64'h44, 1, 1, 64'h2, 0, 0);
        ex(0, 0, 0, 0, 0);
        sc("x0_write", 0, 64'h44, 1, 2, 64'h2, 0, 0);

        ex(1, 1, 1, 7, 64'hDEAD);
        src(1, 64'h10, 2, 64'h20);
        sc("ld_push", 0, 64'h10, 1, 0, 64'h20, 0, 0);
        ex(1, 1, 0, 8, 64'h99);
        src(7, 64'h70, 2, 64'h20);
        sc("ld_haz", 1, 64'h0, 0, 0, 64'h20, 1, 0);
        sc("ld_fwd", 2, 64'hBEEF, 1, 0, 64'h20, 0, 1);

        ex(1, 1, 0, 9, 64'h77);
        stall_in = 1'b1;
        src(8, 64'h80, 9, 64'h90);
        for (int i = 0; i < 3; i++) sc("stall", 1, 64'h99, 1, 0, 64'h90, 0, 1);
        flush = 1'b1;
        sc("flush_stall", 1, 64'h99, 1, 0, 64'h90, 0, 1);
        flush = 1'b0; stall_in = 1'b0;
        ex(0, 0, 0, 0, 0);
        sc("post_flush", 0, 64'h80, 1, 0, 64'h90, 0, 1);

        ex(1, 1, 1, 10, 64'h5);
        src(1, 64'h10, 2, 64'h20);
        sc("sat_ld", 0, 64'h10, 1, 0, 64'h20, 0, 1);
        dut.hazard_count_q = 32'hFFFF_FFFE;
        stall_in = 1'b1;
        ex(1, 1, 0, 12, 64'h3);
        src(10, 64'hA0, 2, 64'h20);
        sc("sat0", 1, 64'h0, 0, 0, 64'h20, 1, 32'hFFFF_FFFE);
        sc("sat1", 1, 64'h0, 0, 0, 64'h20, 1, 32'hFFFF_FFFF);
        sc("sat2", 1, 64'h0, 0, 0, 64'h20, 1, 32'hFFFF_FFFF);
        ex(0, 0, 0, 0, 0);
        sc("haz_noval", 1, 64'h0, 0, 0, 64'h20, 0, 32'hFFFF_FFFF);

        stall_in = 1'b0;
        ex(1, 1, 0, 11, 64'hB1);
        src(11, 64'hB0, 2, 64'h20);
        sc("mr_push", 0, 64'hB0, 1, 0, 64'h20, 0, 32'hFFFF_FFFF);
        ex(0, 0, 0, 0, 0);
        src(11, 64'hB0, 10, 64'hC0);
        rst_n = 1'b0;
        sc("mr_pre", 1, 64'hB1, 1, 2, 64'hBEEF, 0, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        sc("mr_post", 0, 64'hB0, 1, 0, 64'hC0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
